// File: rtl/ap_ctrl_tracker_pkg.sv
// Shared types and constants for the ap_ctrl_hs status tracker.
// Optional latency statistics are enabled with AP_CTRL_TRACKER_LAT_STATS_EN.
package ap_ctrl_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_DONE_WAIT = 2'd2,
    ST_FINISHED  = 2'd3
  } state_t;

  localparam int unsigned ERR_DONE_IDLE  = 0;
  localparam int unsigned ERR_START_DROP = 1;

endpackage

// File: rtl/ap_ctrl_status_tracker_sat_counter.sv
// Saturating up-counter with clear, load-with-one and enable (priority in that order).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         load1,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (load1)
      q <= ONE;
    else if (en && !(&q))
      q <= q + ONE;
  end

endmodule

// File: rtl/ap_ctrl_status_tracker.sv
// Passive observer of one ap_ctrl_hs handshake: state, counters, latency, sticky errors.
// Define AP_CTRL_TRACKER_LAT_STATS_EN to add min_latency/max_latency.
module ap_ctrl_status_tracker
  import ap_ctrl_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LAT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_count,
  output logic [CNT_W-1:0] ready_count,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [LAT_W-1:0] last_latency,
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
  output logic [LAT_W-1:0] min_latency,
  output logic [LAT_W-1:0] max_latency,
`endif
  output logic [1:0]       err
);

  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic ready_seen_q, ready_seen_d;
  logic start_acc, done_acc, ready_ev, busy_en, stall_en;
  logic lat_load, lat_en, lat_rec, err_done_idle, err_start_drop;
  logic [LAT_W-1:0] lat_q, lat_inc, lat_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // finish pre-empts every other event, so nothing below fires in that cycle
  always_comb begin
    state_d        = state_q;
    ready_seen_d   = ready_seen_q;
    start_acc      = 1'b0;
    done_acc       = 1'b0;
    ready_ev       = 1'b0;
    busy_en        = 1'b0;
    stall_en       = 1'b0;
    lat_load       = 1'b0;
    lat_en         = 1'b0;
    lat_rec        = 1'b0;
    err_done_idle  = 1'b0;
    err_start_drop = 1'b0;
    if (finish) begin
      state_d = ST_FINISHED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            start_acc    = 1'b1;
            lat_load     = 1'b1;
            ready_ev     = ap_ready;
            ready_seen_d = ap_ready;
            if (ap_done) begin
              lat_rec = 1'b1;
              if (ap_continue)
                done_acc = 1'b1;
              else
                state_d = ST_DONE_WAIT;
            end else begin
              state_d = ST_ACTIVE;
            end
          end else if (ap_done) begin
            err_done_idle = 1'b1;
          end
        end
        ST_ACTIVE: begin
          busy_en  = 1'b1;
          lat_en   = 1'b1;
          ready_ev = ap_ready;
          if (ap_ready)
            ready_seen_d = 1'b1;
          if (!ap_start && !ready_seen_q)
            err_start_drop = 1'b1;
          if (ap_done) begin
            lat_rec = 1'b1;
            if (ap_continue) begin
              done_acc = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_DONE_WAIT;
            end
          end
        end
        ST_DONE_WAIT: begin
          stall_en = 1'b1;
          if (ap_continue) begin
            done_acc = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Recorded latency includes the done cycle itself, hence one past the running count
  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_ONE;
  assign lat_val = (state_q == ST_IDLE) ? LAT_ONE : lat_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_seen_q <= 1'b0;
      last_latency <= '0;
      err          <= '0;
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
      min_latency  <= '1;
      max_latency  <= '0;
`endif
    end else begin
      ready_seen_q <= ready_seen_d;
      if (err_done_idle)
        err[ERR_DONE_IDLE] <= 1'b1;
      if (err_start_drop)
        err[ERR_START_DROP] <= 1'b1;
      if (lat_rec) begin
        last_latency <= lat_val;
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
        if (lat_val < min_latency)
          min_latency <= lat_val;
        if (lat_val > max_latency)
          max_latency <= lat_val;
`endif
      end
    end
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_start_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(start_acc), .load1(1'b0), .q(start_count)
  );
  sat_counter #(.W(CNT_W)) u_ready_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(ready_ev), .load1(1'b0), .q(ready_count)
  );
  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(done_acc), .load1(1'b0), .q(done_count)
  );
  sat_counter #(.W(CNT_W)) u_busy_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(busy_en), .load1(1'b0), .q(busy_cycles)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(stall_en), .load1(1'b0), .q(stall_cycles)
  );
  sat_counter #(.W(LAT_W)) u_lat_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .en(lat_en), .load1(lat_load), .q(lat_q)
  );

endmodule

// File: tb/tb_ap_ctrl_status_tracker.sv
// Directed bench for ap_ctrl_status_tracker: vector table plus hand-written corner sequences.
// Latency statistics are checked when AP_CTRL_TRACKER_LAT_STATS_EN is defined.
module tb_ap_ctrl_status_tracker;

  logic        clock, reset;
  logic        ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]  state, err;
  logic [31:0] start_count, ready_count, done_count, busy_cycles, stall_cycles, last_latency;
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
  logic [31:0] min_latency, max_latency;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  ap_ctrl_status_tracker #(.CNT_W(32), .LAT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_count(start_count), .ready_count(ready_count),
    .done_count(done_count), .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
    .last_latency(last_latency),
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
    .min_latency(min_latency), .max_latency(max_latency),
`endif
    .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit s, r, d, c, f;
    int unsigned st, sc, rc, dc, busy, stall, last, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit s, bit r, bit d, bit c, bit f, int unsigned st,
                              int unsigned sc, int unsigned rc, int unsigned dc,
                              int unsigned busy, int unsigned stall, int unsigned last,
                              int unsigned e);
    vec_t v;
    v.s = s; v.r = r; v.d = d; v.c = c; v.f = f;
    v.st = st; v.sc = sc; v.rc = rc; v.dc = dc;
    v.busy = busy; v.stall = stall; v.last = last; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic apply(input bit s, input bit r, input bit d, input bit c, input bit f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int unsigned st, input int unsigned sc,
                         input int unsigned rc, input int unsigned dc, input int unsigned busy,
                         input int unsigned stall, input int unsigned last, input int unsigned e);
    chk({tag, ".state"}, state, st);
    chk({tag, ".start_count"}, start_count, sc);
    chk({tag, ".ready_count"}, ready_count, rc);
    chk({tag, ".done_count"}, done_count, dc);
    chk({tag, ".busy_cycles"}, busy_cycles, busy);
    chk({tag, ".stall_cycles"}, stall_cycles, stall);
    chk({tag, ".last_latency"}, last_latency, last);
    chk({tag, ".err"}, err, e);
  endtask

  task automatic run_txn(input int unsigned l);
    if (l > 1) repeat (l - 1) apply(1, 0, 0, 1, 0);
    apply(1, 1, 1, 1, 0);
    chk($sformatf("txn%0d.last_latency", l), last_latency, l);
    chk($sformatf("txn%0d.state", l), state, 0);
    apply(0, 0, 0, 1, 0);
  endtask

  initial begin
    // normal transaction, stalled done, single-cycle transaction, then a stray done
    vecs.push_back(mk(0,0,0,1,0, 0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 1,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 1,0,0, 1,0,0, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 1,0,0, 2,0,0, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 1,0,0, 3,0,0, 0));
    vecs.push_back(mk(1,1,1,1,0, 0, 1,1,1, 4,0,5, 0));
    vecs.push_back(mk(0,0,0,1,0, 0, 1,1,1, 4,0,5, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 2,1,1, 4,0,5, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 2,1,1, 5,0,5, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 2,1,1, 6,0,5, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 2,1,1, 7,0,5, 0));
    vecs.push_back(mk(1,1,1,0,0, 2, 2,2,1, 8,0,5, 0));
    vecs.push_back(mk(0,0,1,0,0, 2, 2,2,1, 8,1,5, 0));
    vecs.push_back(mk(0,0,1,0,0, 2, 2,2,1, 8,2,5, 0));
    vecs.push_back(mk(0,0,1,1,0, 0, 2,2,2, 8,3,5, 0));
    vecs.push_back(mk(1,1,1,1,0, 0, 3,3,3, 8,3,1, 0));
    vecs.push_back(mk(0,0,0,1,0, 0, 3,3,3, 8,3,1, 0));
    vecs.push_back(mk(0,0,1,1,0, 0, 3,3,3, 8,3,1, 1));
    vecs.push_back(mk(0,0,0,1,0, 0, 3,3,3, 8,3,1, 1));
    vecs.push_back(mk(0,0,0,1,0, 0, 3,3,3, 8,3,1, 1));

    do_reset();
    chk_all("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
    chk("reset0.min_latency", min_latency, 32'hFFFF_FFFF);
    chk("reset0.max_latency", max_latency, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].s, vecs[i].r, vecs[i].d, vecs[i].c, vecs[i].f);
      chk_all($sformatf("row%0d", i), vecs[i].st, vecs[i].sc, vecs[i].rc, vecs[i].dc,
              vecs[i].busy, vecs[i].stall, vecs[i].last, vecs[i].err);
    end

    // start dropped before ready
    do_reset();
    apply(1, 0, 0, 1, 0);
    chk("drop.state", state, 1);
    apply(1, 0, 0, 1, 0);
    chk("drop.err_before", err, 0);
    apply(0, 0, 0, 1, 0);
    chk("drop.err", err, 2);
    apply(0, 1, 1, 1, 0);
    chk_all("drop.done", 0, 1, 1, 1, 3, 0, 4, 2);
    apply(0, 0, 0, 1, 0);
    chk("drop.err_sticky", err, 2);

    // finish mid-ACTIVE freezes everything
    do_reset();
    apply(1, 0, 0, 1, 0);
    apply(1, 1, 0, 1, 0);
    apply(0, 0, 1, 1, 1);
    chk_all("fin", 3, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk_all($sformatf("frozen%0d", i), 3, 1, 1, 0, 1, 0, 0, 0);
    end

    // asynchronous reset pulse, taken between clock edges
    #3 reset = 1'b1;
    #1 chk_all("areset_fin", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    apply(1, 1, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    chk_all("pre_areset", 1, 1, 1, 0, 1, 0, 0, 0);
    #3 reset = 1'b1;
    #1 chk_all("areset_act", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
    chk("areset.min_latency", min_latency, 32'hFFFF_FFFF);
    chk("areset.max_latency", max_latency, 0);
`endif
    @(posedge clock);
    #1 reset = 1'b0;

    // three transactions of latency 4, 9 and 2
    run_txn(4);
    run_txn(9);
    run_txn(2);
    chk_all("stats", 0, 3, 3, 3, 12, 0, 2, 0);
`ifdef AP_CTRL_TRACKER_LAT_STATS_EN
    chk("stats.min_latency", min_latency, 2);
    chk("stats.max_latency", max_latency, 9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
